// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard control path.
package pipeline_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
  localparam int WAIT_CNT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes and status out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [pipeline_ctrl_pkg::REG_ADDR_W-1:0] id_rs1;
  logic [pipeline_ctrl_pkg::REG_ADDR_W-1:0] id_rs2;
  logic                                     id_uses_rs1;
  logic                                     id_uses_rs2;
  logic [pipeline_ctrl_pkg::REG_ADDR_W-1:0] ex_rd;
  logic                                     ex_mem_read;
  logic                                     ex_branch_taken;
  logic                                     mem_req;
  logic                                     mem_ready;

  logic             pc_enable;
  logic             pc_sel_target;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_enable;
  logic             id_ex_flush;
  logic             ex_mem_enable;
  logic             mem_wb_enable;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_enable, pc_sel_target, if_id_enable, if_id_flush, id_ex_enable,
           id_ex_flush, ex_mem_enable, mem_wb_enable, mem_wb_flush,
           mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_enable, pc_sel_target, if_id_enable, if_id_flush, id_ex_enable,
           id_ex_flush, ex_mem_enable, mem_wb_enable, mem_wb_flush,
           mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/load_use_detector.sv
// Combinational load-use comparator: flags an ID source that depends on a load in EX.
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hazard
);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = mem_read && (rd != REG_X0) &&
                  ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: zero-latency stage controls from state and hazards,
// priority memory wait > branch redirect > load-use; memory wait freezes all upstream stages.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hc
);
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  load_use;
  logic                  mem_stall;

  load_use_detector u_load_use (
    .rs1      (hc.id_rs1),
    .rs2      (hc.id_rs2),
    .uses_rs1 (hc.id_uses_rs1),
    .uses_rs2 (hc.id_uses_rs2),
    .rd       (hc.ex_rd),
    .mem_read (hc.ex_mem_read),
    .hazard   (load_use)
  );

  // Once waiting, only mem_ready releases; mem_req need not stay asserted.
  always_comb begin
    mem_stall = 1'b0;
    if (state == MEM_WAIT) mem_stall = !hc.mem_ready;
    else                   mem_stall = hc.mem_req && !hc.mem_ready;
  end

  always_comb begin
    hc.pc_enable     = 1'b1;
    hc.pc_sel_target = 1'b0;
    hc.if_id_enable  = 1'b1;
    hc.if_id_flush   = 1'b0;
    hc.id_ex_enable  = 1'b1;
    hc.id_ex_flush   = 1'b0;
    hc.ex_mem_enable = 1'b1;
    hc.mem_wb_enable = 1'b1;
    hc.mem_wb_flush  = 1'b0;
    if (reset) begin
      hc.pc_enable     = 1'b0;
      hc.if_id_enable  = 1'b0;
      hc.id_ex_enable  = 1'b0;
      hc.ex_mem_enable = 1'b0;
      hc.mem_wb_enable = 1'b0;
    end else if (mem_stall) begin
      hc.pc_enable     = 1'b0;
      hc.if_id_enable  = 1'b0;
      hc.id_ex_enable  = 1'b0;
      hc.ex_mem_enable = 1'b0;
      hc.mem_wb_flush  = 1'b1;
    end else if (hc.ex_branch_taken) begin
      // Squashing ID also discards any load-use dependency it carried.
      hc.pc_sel_target = 1'b1;
      hc.if_id_flush   = 1'b1;
      hc.id_ex_flush   = 1'b1;
    end else if (load_use) begin
      hc.pc_enable    = 1'b0;
      hc.if_id_enable = 1'b0;
      hc.id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      wait_cnt       <= '0;
      hc.mem_timeout <= 1'b0;
      hc.stall_count <= '0;
      hc.flush_count <= '0;
    end else begin
      state <= mem_stall ? MEM_WAIT : RUN;
      if ((state == MEM_WAIT) && mem_stall) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        if (wait_cnt + WAIT_CNT_W'(1) == TIMEOUT_LIM) hc.mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (!hc.pc_enable)    hc.stall_count <= hc.stall_count + CNT_W'(1);
      if (hc.pc_sel_target) hc.flush_count <= hc.flush_count + CNT_W'(1);
    end
  end
endmodule
